// File: rtl/ascii_uart_tx_pkg.sv
// Shared definitions for the ASCII UART transmitter: FSM states, default
// parameters and the 8N1 frame length.
package ascii_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_FIFO_DEPTH   = 4;
    localparam int FRAME_BITS           = 10;

endpackage

// File: rtl/char_fifo.sv
// Generic byte FIFO with occupancy count; knows nothing about serial framing.
// Pushes while full and pops while empty are ignored.
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ascii_uart_tx.sv
// 8N1 serial transmitter fed from a small character FIFO; frames go out
// back-to-back with no idle gap while the FIFO holds data.
module ascii_uart_tx
    import ascii_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [11:0] BAUD_LAST = 12'(CLKS_PER_BIT - 1);

    tx_state_t   state;
    tx_state_t   state_next;
    logic [11:0] baud_cnt;
    logic [11:0] baud_next;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_next;
    logic [7:0]  shifter;
    logic [7:0]  shift_next;
    logic        tx_reg;
    logic        tx_next;
    logic        bit_end;

    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [LVL_W-1:0] fifo_lvl;

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_lvl)
    );

    assign in_ready   = !fifo_full;
    assign fifo_level = 3'(fifo_lvl);
    assign busy       = (state != IDLE) || !fifo_empty;
    assign tx         = tx_reg;
    assign bit_end    = (baud_cnt == BAUD_LAST);

    // The shifter holds the popped byte unchanged; bit_idx selects what goes on the line.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shifter;
        tx_next    = tx_reg;
        fifo_pop   = 1'b0;

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    baud_next  = '0;
                    bit_next   = '0;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    tx_next    = shifter[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 12'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_next   = '0;
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        tx_next  = shifter[bit_idx + 3'd1];
                    end
                end else begin
                    baud_next = baud_cnt + 12'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    bit_next  = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_dout;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 12'd1;
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_reg   <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            tx_reg   <= tx_next;
        end
    end

    always_ff @(posedge clk) begin
        shifter <= shift_next;
    end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Scoreboard bench for ascii_uart_tx: accepted bytes are queued as expected
// frames and a line monitor decodes tx and compares each complete frame.
module tb_ascii_uart_tx;
    import ascii_uart_tx_pkg::*;

    localparam int CPB          = 4;
    localparam int DEPTH        = 4;
    localparam int FRAME_CYCLES = FRAME_BITS * CPB;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         frame_start[$];
    int         frame_end[$];
    int         mon_cnt   = 0;
    int         mon_start = 0;
    logic [FRAME_CYCLES-1:0] samples;

    ascii_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // A frame on the wire is start(0), eight data bits LSB first, stop(1), each CPB cycles.
    task automatic check_frame();
        logic [7:0]              b;
        logic [FRAME_BITS-1:0]   bits;
        logic [FRAME_CYCLES-1:0] want;
        frame_start.push_back(mon_start);
        frame_end.push_back(cyc + 1);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL frame: unexpected frame, got samples %h, want none", samples);
        end else begin
            b    = exp_q.pop_front();
            bits = {1'b1, b, 1'b0};
            for (int i = 0; i < FRAME_CYCLES; i++) begin
                want[i] = bits[i / CPB];
            end
            if (samples !== want) begin
                bad++;
                $display("[TB] FAIL frame: byte %02h got samples %h, want %h", b, samples, want);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_cnt = 0;
            end else if (mon_cnt == 0) begin
                if (tx == 1'b0) begin
                    samples    = '0;
                    samples[0] = tx;
                    mon_start  = cyc;
                    mon_cnt    = 1;
                end
            end else begin
                samples[mon_cnt] = tx;
                mon_cnt++;
                if (mon_cnt == FRAME_CYCLES) begin
                    check_frame();
                    mon_cnt = 0;
                end
            end
        end
    end

    // Called just after a falling edge; returns one falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back(b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_with_latency_check(input logic [7:0] b, input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_data  = b;
        in_valid = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_tx_before_start"}, 32'(tx), 32'd1);
        check({tag, "_level_after_accept"}, 32'(fifo_level), 32'd1);
        @(negedge clk);
        check({tag, "_tx_start"}, 32'(tx), 32'd0);
        check({tag, "_level_after_pop"}, 32'(fifo_level), 32'd0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0 || mon_cnt != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy || exp_q.size() != 0 || mon_cnt != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic wait_tx_low(input int budget);
        int n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            check("tx_low_timeout", 32'(tx), 32'd0);
        end
    endtask

    initial begin
        int n;
        int accepted;
        int base;
        int gaps;
        int lows;
        logic [7:0] quetzal [7];
        quetzal = '{8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61, 8'h6C};

        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 'G': one-cycle latency, then busy for exactly one frame.
        send_with_latency_check(8'h47, "g");
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("g_busy_cycles", 32'(n), 32'd40);
        wait_drain(200);

        // in_valid held for 10 cycles from idle: shifter takes one, FIFO fills to four.
        accepted = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'($urandom_range(0, 255));
            if (i == 5) begin
                check("hold_ready_6th", 32'(in_ready), 32'd0);
            end
            if (in_ready) begin
                exp_q.push_back(in_data);
                accepted++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("hold_accepted", 32'(accepted), 32'd5);
        check("hold_level", 32'(fifo_level), 32'd4);
        wait_drain(400);

        // "Quetzal" streamed back-to-back.
        base = frame_start.size();
        for (int i = 0; i < 7; i++) begin
            send_byte(quetzal[i]);
        end
        n = 0;
        while (frame_start.size() < base + 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("quetzal_frames", 32'(frame_start.size() - base), 32'd7);
        if (frame_start.size() >= base + 7) begin
            check("quetzal_span", 32'(frame_end[base + 6] - frame_start[base]), 32'd280);
            gaps = 0;
            for (int k = 0; k < 6; k++) begin
                if (frame_start[base + k + 1] != frame_end[base + k]) gaps++;
            end
            check("quetzal_gaps", 32'(gaps), 32'd0);
        end
        wait_drain(200);

        // Reset during data bit 3 with two bytes queued.
        send_byte(8'($urandom_range(0, 255)));
        wait_tx_low(20);
        send_byte(8'($urandom_range(0, 255)));
        send_byte(8'($urandom_range(0, 255)));
        repeat (15) @(negedge clk);
        check("rst_pre_level", 32'(fifo_level), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check("rst_no_frames", 32'(lows), 32'd0);
        check("rst_idle_busy", 32'(busy), 32'd0);
        send_with_latency_check(8'($urandom_range(0, 255)), "post_rst");
        wait_drain(200);

        // Push coinciding with the end-of-frame pop at level 2.
        send_byte(8'hA1);
        wait_tx_low(20);
        send_byte(8'hB2);
        send_byte(8'hC3);
        repeat (37) @(negedge clk);
        check("pp_level_before", 32'(fifo_level), 32'd2);
        send_byte(8'hD4);
        check("pp_level_after", 32'(fifo_level), 32'd2);
        check("pp_next_start", 32'(tx), 32'd0);
        wait_drain(400);

        // All-zero and all-one data bytes.
        send_byte(8'h00);
        send_byte(8'hFF);
        wait_drain(200);

        // Random bytes with random gaps, including FIFO back-pressure.
        for (int i = 0; i < 24; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_drain(2000);

        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("[TB] FAIL watchdog: got no completion, want completion within limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ascii_uart_tx.md
ASCII_UART_TX -- requirements
Module: ascii_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set the clock cycles per serial bit; legal range 2..4095.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the number of byte entries in the input FIFO; fixed power of two.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  8  ASCII character from the upstream character sequencer.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts a byte this cycle.
REQ-008 tx  output  1  serial line, 8N1, idle high, registered.
REQ-009 busy  output  1  high while a frame is in flight or the FIFO is non-empty.
REQ-010 fifo_level  output  3  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-011 A byte SHALL be accepted on a rising edge where in_valid and in_ready are both high; no other transfer exists.
REQ-012 in_ready SHALL equal (fifo_level < FIFO_DEPTH), driven from registered state only, with no combinational path from in_valid.
REQ-013 The FIFO SHALL be first-in first-out; a simultaneous push and pop SHALL leave fifo_level unchanged and lose no data.
REQ-014 The FSM SHALL have states IDLE, START, DATA and STOP; it SHALL be IDLE after reset.
REQ-015 In IDLE with fifo_level != 0, the next edge SHALL pop the head byte into the shift register, enter START and drive tx low.
REQ-016 The minimum latency SHALL be one cycle: a byte accepted at edge N into an empty, idle block drives tx low at edge N+1.
REQ-017 START SHALL hold tx=0 for CLKS_PER_BIT cycles.
REQ-018 DATA SHALL then send bits 0..7, LSB first, each for CLKS_PER_BIT cycles.
REQ-019 STOP SHALL then hold tx=1 for CLKS_PER_BIT cycles.
REQ-020 A baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; a 3-bit index SHALL count data bits 0..7.
REQ-021 On the last STOP cycle, if fifo_level != 0 the FSM SHALL pop and go directly to START, giving zero idle cycles between frames; otherwise it SHALL go to IDLE.
REQ-022 A byte SHALL never be altered once popped; pushes during a frame affect only the FIFO.
REQ-023 While the FIFO is full, in_valid SHALL be ignored and no overwrite SHALL occur.
REQ-024 busy SHALL be (state != IDLE) OR (fifo_level != 0).

Reset
REQ-025 Asserting rst_n low SHALL immediately force tx=1, busy=0, fifo_level=0, in_ready=1, state IDLE, and zero all counters.
REQ-026 Reset mid-frame SHALL abort the frame and discard all FIFO contents; the first frame after release follows REQ-015 and REQ-016.
REQ-027 Shift register and FIFO storage need no reset value; pointers and counters SHALL be reset.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE, START, DATA, STOP), the default CLKS_PER_BIT and FIFO_DEPTH constants, and the frame length constant (10 bits).
REQ-029 The FIFO SHALL be a sub-module, char_fifo, with push/pop/full/empty/level ports and no knowledge of UART framing.
REQ-030 The FSM, baud counter and shift register SHALL live in ascii_uart_tx.

Verification (CLKS_PER_BIT=4)
REQ-031 Push a single 0x47 ('G') while idle:
- tx low one cycle after accept.
- tx sequence 0,1,1,1,0,0,0,1,0,1, each bit held 4 cycles.
- busy drops after 40 cycles.
REQ-032 Hold in_valid high for 10 cycles while idle:
- exactly 5 bytes accepted (1 in shifter, 4 in FIFO).
- in_ready low from the 6th cycle.
- fifo_level=4.
REQ-033 Stream "Quetzal" (0x51,0x75,0x65,0x74,0x7A,0x61,0x6C):
- 7 frames decoded in order.
- no high gap between a stop bit and the next start bit.
- total 280 cycles from first start bit to last stop-bit end.
REQ-034 Assert rst_n low during bit 3 of a frame with 2 bytes queued:
- tx=1 and fifo_level=0 immediately.
- no further frames after release until a new push.
REQ-035 Push and pop in the same cycle at fifo_level=2:
- fifo_level stays 2.
- byte order preserved on tx.
REQ-036 Push 0x00 then 0xFF:
- frames are 0,0,0,0,0,0,0,0,0,1 and 0,1,1,1,1,1,1,1,1,1.
